// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage LEGv8 pipeline (load-use, memory wait with timeout, MEM-stage branch).
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter logic [4:0] XZR_IDX     = 5'd31,
  parameter int         MEM_TIMEOUT = 255,
  parameter int         TO_W        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_rd,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        mem_branch_taken,
  output logic        pc_en,
  output logic        pc_sel_branch,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;
  state_e state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_wait, load_use;
  assign mem_wait = (state_q != HALT) && mem_access && !mem_ready;
  assign load_use = id_valid && ex_memRead && (ex_rd != XZR_IDX) && (ex_rd == id_rs1 || ex_rd == id_rs2);
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    halted        = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_q == HALT) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      halted    = 1'b1;
    end else if (mem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      wait_cnt_d   = wait_cnt_q + TO_W'(1);
      state_d      = (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1)) ? HALT : MEM_WAIT;
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (mem_branch_taken) begin
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(!pc_en);
      flush_q <= flush_q + 32'(pc_sel_branch);
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plan sequences plus random stimulus against a priority-rule reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  logic clock = 1'b0;
  logic reset, id_valid, ex_memRead, mem_access, mem_ready, mem_branch_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted;
  logic [31:0] stall_cycles, flush_count;
  int checks = 0, errors = 0;
  bit m_halt;
  int m_waits;
  logic [31:0] m_stall, m_flush;
  always #5 clock = ~clock;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_access(mem_access), .mem_ready(mem_ready),
    .mem_branch_taken(mem_branch_taken), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                      input logic mr, input logic [4:0] rd, input logic ma, input logic rdy, input logic br);
    logic wait_c, lu;
    logic [10:0] e, g;
    @(negedge clock);
    reset = r; id_valid = iv; id_rs1 = s1; id_rs2 = s2; ex_memRead = mr; ex_rd = rd;
    mem_access = ma; mem_ready = rdy; mem_branch_taken = br;
    #1;
    wait_c = !m_halt && ma && !rdy;
    lu = iv && mr && rd != 5'd31 && (rd == s1 || rd == s2);
    // bit order: pc_en, pc_sel, en[if_id,id_ex,ex_mem,mem_wb], flush[same order], halted
    if (r)           e = {2'b00, 4'b1111, 4'b1111, 1'b0};
    else if (m_halt) e = {2'b00, 4'b0000, 4'b0000, 1'b1};
    else if (wait_c) e = {2'b00, 4'b0001, 4'b0001, 1'b0};
    else if (br)     e = {2'b11, 4'b1111, 4'b1110, 1'b0};
    else if (lu)     e = {2'b00, 4'b0111, 4'b0100, 1'b0};
    else             e = {2'b10, 4'b1111, 4'b0000, 1'b0};
    g = {pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted};
    check("ctrl", 32'(g), 32'(e));
`ifdef PIPE_HAZARD_PERF_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_count", flush_count, m_flush);
`else
    check("stall_cycles", stall_cycles, 32'd0);
    check("flush_count", flush_count, 32'd0);
`endif
    if (r) begin
      m_halt = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    end else if (m_halt) begin
      m_stall++;
    end else if (wait_c) begin
      m_stall++;
      m_waits++;
      if (m_waits >= TO) m_halt = 1;
    end else begin
      m_waits = 0;
      if (br) m_flush++;
      else if (lu) m_stall++;
    end
  endtask
  task automatic idle(input logic ma, input logic rdy, input logic br);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, ma, rdy, br);
  endtask
  initial begin
    m_halt = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    check("halted_after_reset", 32'(halted), 32'd0);
    check("pc_en_after_reset", 32'(pc_en), 32'd1);
    step(0, 1, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0);
    step(0, 1, 5'd3, 5'd5, 0, 5'd5, 0, 0, 0);
    step(0, 1, 5'd31, 5'd31, 1, 5'd31, 0, 0, 0);
    step(0, 1, 5'd7, 5'd2, 1, 5'd7, 0, 0, 0);
    step(0, 0, 5'd7, 5'd7, 1, 5'd7, 0, 0, 0);
    repeat (3) idle(1, 0, 0);
    idle(1, 1, 0);
    idle(0, 0, 0);
    step(0, 1, 5'd5, 5'd9, 1, 5'd5, 0, 0, 1);
    idle(0, 0, 0);
    repeat (2) idle(1, 0, 1);
    idle(1, 1, 1);
    idle(0, 0, 0);
    repeat (TO + 2) idle(1, 0, 0);
    check("halted_sticky", 32'(halted), 32'd1);
    idle(0, 1, 1);
    step(1'b1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 0, 0);
    check("halted_cleared", 32'(halted), 32'd0);
    repeat (3000) begin
      logic ma;
      ma = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 80) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
           1'($urandom), ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
           ma, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
    end
    idle(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LEGv8 pipeline. Drives load-enable and flush (bubble) controls of IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC enable.
- Resolves three events: load-use hazards, data-memory wait states (ready handshake) and taken branches resolved in MEM.
- Holds a small FSM for memory waits, with a timeout into a sticky HALT state.

Parameters:
- XZR_IDX, 31, register index never treated as a hazard source (hard-wired zero register).
- MEM_TIMEOUT, 255, maximum consecutive wait cycles before HALT; 1..65535.
- TO_W, 16, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- ex_memRead  in  1  EX-stage instruction is a load (LDUR).
- ex_rd  in  5  EX-stage destination register.
- mem_access  in  1  MEM-stage instruction reads or writes data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- mem_branch_taken  in  1  MEM-stage branch/CBZ resolved taken.
- pc_en  out  1  PC loads next value.
- pc_sel_branch  out  1  PC next = branch target.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enable.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads zero controls (bubble); flush overrides en.
- halted  out  1  sticky memory-timeout error.
- stall_cycles  out  32  perf counter (see Optional Feature).
- flush_count  out  32  perf counter (see Optional Feature).

Behaviour:
- Outputs are combinational (Mealy) from state and inputs; state, wait counter and perf counters are registered.
- States: RUN, MEM_WAIT, HALT.
- Reset (reset=1 on a clock edge): state=RUN, wait_cnt=0, halted=0, counters=0.
- While reset is high: all four flush=1, all en=1, pc_en=0, pc_sel_branch=0, so every pipeline register clears. Reset mid-wait abandons the wait.
- Priority within a cycle: HALT > mem wait > branch > load-use > normal.
- HALT: all en=0, all flush=0, pc_en=0, halted=1. Exits only by reset.
- Mem wait condition (state RUN or MEM_WAIT, mem_access=1, mem_ready=0):
  - pc_en=if_id_en=id_ex_en=ex_mem_en=0.
  - mem_wb_en=1 with mem_wb_flush=1, so WB sees a bubble each wait cycle.
  - mem_branch_taken is ignored.
  - Next state MEM_WAIT; wait_cnt increments.
  - If wait_cnt reaches MEM_TIMEOUT-1 on a wait cycle, next state is HALT.
- Wait complete (MEM_WAIT, mem_ready=1, or mem_access dropped): behave exactly as RUN for this cycle; next state RUN; wait_cnt=0.
- A zero-wait access (mem_ready=1 in the first cycle) never leaves RUN.
- Branch (RUN path, mem_branch_taken=1):
  - pc_en=1, pc_sel_branch=1.
  - if_id_flush=id_ex_flush=ex_mem_flush=1; mem_wb_en=1, no flush.
  - Load-use is suppressed this cycle.
- Load-use, evaluated only if no branch. Condition: id_valid & ex_memRead & ex_rd!=XZR_IDX & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - pc_en=0, if_id_en=0.
  - id_ex_en=1 with id_ex_flush=1.
  - ex_mem_en=mem_wb_en=1.
  - Exactly one bubble: next cycle EX holds the bubble, so the condition clears.
- Normal: all en=1, all flush=0, pc_en=1, pc_sel_branch=0.
- Counter wrap: 32-bit counters wrap modulo 2^32; wait_cnt saturates in HALT.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every clock where pc_en=0 and not in reset (includes HALT).
  - flush_count increments on every branch flush cycle.
- Undefined: both ports tied to 32'd0 and no counter flops are synthesised; ports remain present.

Test Plan:
- Reset held 2 cycles -> all flush=1, all en=1, pc_en=0. After release: state RUN, halted=0, pc_en=1, counters 0.
- ex_memRead=1, ex_rd=5, id_rs2=5, id_valid=1 for one cycle, then ex_memRead=0 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; then normal. With ex_rd=31, no stall.
- mem_access=1, mem_ready low 3 cycles then high -> 3 cycles of pc_en=0, ex_mem_en=0, mem_wb_flush=1; 4th cycle normal. stall_cycles=3 with PIPE_HAZARD_PERF_EN.
- mem_branch_taken=1 together with a load-use match -> pc_sel_branch=1, pc_en=1, if_id/id_ex/ex_mem_flush=1, no load-use stall. flush_count=1.
- mem_branch_taken=1 during a mem wait -> branch ignored until mem_ready=1, then the flush happens in the mem_ready cycle.
- MEM_TIMEOUT=4, mem_access=1, mem_ready=0 held -> HALT after 4 wait cycles, halted=1 sticky. Asserting reset -> RUN, halted=0.
